// File: rtl/operand_fetch_if.sv
// operand_fetch_if: instruction, write-back and ALU-bundle signals of the operand-fetch stage
interface operand_fetch_if;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic        flush;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_in1;
   logic [31:0] ex_in2;
   logic [2:0]  ex_func3;
   logic        ex_opequal;
   logic [4:0]  ex_rd;
   logic        illegal;

   modport master (
      output instr_valid, instr, flush, wb_en, wb_rd, wb_data, ex_ready,
      input  instr_ready, ex_valid, ex_in1, ex_in2, ex_func3, ex_opequal, ex_rd, illegal
   );

   modport slave (
      input  instr_valid, instr, flush, wb_en, wb_rd, wb_data, ex_ready,
      output instr_ready, ex_valid, ex_in1, ex_in2, ex_func3, ex_opequal, ex_rd, illegal
   );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: RV32I OP/OP-IMM decode, register-file read with write-back bypass, registered ALU bundle
module operand_fetch #(
   parameter bit BYPASS_EN = 1'b1
) (
   input logic           clk,
   input logic           rst_n,
   operand_fetch_if.slave bus
);
   logic [31:0] rf_q [0:31];
   logic        ex_valid_q, illegal_q, opequal_q, use2_q;
   logic [31:0] in1_q, in2_q;
   logic [2:0]  func3_q;
   logic [4:0]  rd_q, rs1_q, rs2_q;
   logic [6:0]  opcode, f7;
   logic [2:0]  f3;
   logic [4:0]  rs1, rs2;
   logic        is_op, is_imm, shift_imm, legal_d, opequal_d, accept, load;
   logic [31:0] rv1, rv2, in2_d;

   // decode the offered instruction and read operands, forwarding a same-cycle write-back
   always_comb begin
      opcode    = bus.instr[6:0];
      f7        = bus.instr[31:25];
      f3        = bus.instr[14:12];
      rs1       = bus.instr[19:15];
      rs2       = bus.instr[24:20];
      is_op     = opcode == 7'b0110011;
      is_imm    = opcode == 7'b0010011;
      shift_imm = f3 == 3'b001 || f3 == 3'b101;
      legal_d   = is_op ? (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) :
                  is_imm ? (f3 == 3'b001 ? f7 == 7'b0000000 :
                            f3 == 3'b101 ? (f7 == 7'b0000000 || f7 == 7'b0100000) : 1'b1) : 1'b0;
      rv1       = rs1 == 5'd0 ? 32'd0 :
                  (BYPASS_EN && bus.wb_en && bus.wb_rd == rs1) ? bus.wb_data : rf_q[rs1];
      rv2       = rs2 == 5'd0 ? 32'd0 :
                  (BYPASS_EN && bus.wb_en && bus.wb_rd == rs2) ? bus.wb_data : rf_q[rs2];
      in2_d     = is_op ? rv2 : shift_imm ? {27'd0, rs2} : {{20{bus.instr[31]}}, bus.instr[31:20]};
      opequal_d = is_op ? bus.instr[30] : (f3 == 3'b101 && bus.instr[30]);
      accept    = bus.instr_valid && bus.instr_ready;
      load      = accept && legal_d;
   end

   // architectural register file; x0 is never written
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      else if (bus.wb_en && bus.wb_rd != 5'd0)
         rf_q[bus.wb_rd] <= bus.wb_data;

   // single-entry output bundle: load, consume, flush, and refresh of stalled operands
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ex_valid_q <= 1'b0;
         illegal_q  <= 1'b0;
         in1_q      <= '0;
         in2_q      <= '0;
         func3_q    <= '0;
         opequal_q  <= 1'b0;
         rd_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         use2_q     <= 1'b0;
      end else begin
         illegal_q <= accept && !legal_d;
         if (bus.flush)
            ex_valid_q <= 1'b0;
         else if (load) begin
            ex_valid_q <= 1'b1;
            in1_q      <= rv1;
            in2_q      <= in2_d;
            func3_q    <= f3;
            opequal_q  <= opequal_d;
            rd_q       <= bus.instr[11:7];
            rs1_q      <= rs1;
            rs2_q      <= rs2;
            use2_q     <= is_op;
         end else if (ex_valid_q && bus.ex_ready)
            ex_valid_q <= 1'b0;
         else if (ex_valid_q && BYPASS_EN && bus.wb_en && bus.wb_rd != 5'd0) begin
            if (bus.wb_rd == rs1_q) in1_q <= bus.wb_data;
            if (use2_q && bus.wb_rd == rs2_q) in2_q <= bus.wb_data;
         end
      end

   assign bus.instr_ready = !bus.flush && (!ex_valid_q || bus.ex_ready);
   assign bus.ex_valid    = ex_valid_q;
   assign bus.ex_in1      = in1_q;
   assign bus.ex_in2      = in2_q;
   assign bus.ex_func3    = func3_q;
   assign bus.ex_opequal  = opequal_q;
   assign bus.ex_rd       = rd_q;
   assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed checks of decode, bypass, stall refresh, illegal, flush and reset
module tb_operand_fetch;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;

   operand_fetch_if b1 ();
   operand_fetch_if b0 ();

   operand_fetch #(.BYPASS_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   operand_fetch #(.BYPASS_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

   assign b0.instr_valid = b1.instr_valid;
   assign b0.instr       = b1.instr;
   assign b0.flush       = b1.flush;
   assign b0.wb_en       = b1.wb_en;
   assign b0.wb_rd       = b1.wb_rd;
   assign b0.wb_data     = b1.wb_data;
   assign b0.ex_ready    = b1.ex_ready;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] ins);
      b1.instr_valid = 1'b1;
      b1.instr = ins;
   endtask

   task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
      b1.wb_en = en;
      b1.wb_rd = rd;
      b1.wb_data = d;
   endtask

   task automatic chk_bundle(input string tag, input logic [31:0] i1, input logic [31:0] i2,
                             input logic [2:0] f3, input logic oe, input logic [4:0] rd);
      chk({tag, "_valid"}, {31'd0, b1.ex_valid}, 32'd1);
      chk({tag, "_in1"}, b1.ex_in1, i1);
      chk({tag, "_in2"}, b1.ex_in2, i2);
      chk({tag, "_func3"}, {29'd0, b1.ex_func3}, {29'd0, f3});
      chk({tag, "_opequal"}, {31'd0, b1.ex_opequal}, {31'd0, oe});
      chk({tag, "_rd"}, {27'd0, b1.ex_rd}, {27'd0, rd});
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, {31'd0, b1.ex_valid}, 32'd0);
      chk({tag, "_in1"}, b1.ex_in1, 32'd0);
      chk({tag, "_in2"}, b1.ex_in2, 32'd0);
      chk({tag, "_func3"}, {29'd0, b1.ex_func3}, 32'd0);
      chk({tag, "_opequal"}, {31'd0, b1.ex_opequal}, 32'd0);
      chk({tag, "_rd"}, {27'd0, b1.ex_rd}, 32'd0);
      chk({tag, "_illegal"}, {31'd0, b1.illegal}, 32'd0);
   endtask

   initial begin
      b1.instr_valid = 1'b0;
      b1.instr = '0;
      b1.flush = 1'b0;
      b1.ex_ready = 1'b1;
      wb(1'b0, 5'd0, 32'd0);
      #12;
      chk_zero("rst");
      chk("rst_instr_ready", {31'd0, b1.instr_ready}, 32'd1);
      #2 rst_n = 1'b1;
      tick();
      wb(1'b1, 5'd1, 32'd5);
      tick();
      wb(1'b1, 5'd2, 32'd3);
      tick();
      wb(1'b0, 5'd0, 32'd0);
      issue(32'h402081B3);
      tick();
      chk_bundle("sub", 32'd5, 32'd3, 3'b000, 1'b1, 5'd3);
      issue(32'hFFF00213);
      tick();
      chk_bundle("addi", 32'd0, 32'hFFFFFFFF, 3'b000, 1'b0, 5'd4);
      issue(32'h4040D293);
      tick();
      chk_bundle("srai", 32'd5, 32'd4, 3'b101, 1'b1, 5'd5);
      issue(32'h00208333);
      tick();
      chk_bundle("add", 32'd5, 32'd3, 3'b000, 1'b0, 5'd6);
      b1.instr_valid = 1'b0;
      b1.ex_ready = 1'b0;
      #1;
      chk("stall_ready", {31'd0, b1.instr_ready}, 32'd0);
      wb(1'b1, 5'd2, 32'h77);
      tick();
      chk_bundle("refresh", 32'd5, 32'h77, 3'b000, 1'b0, 5'd6);
      chk("nobyp_refresh_in2", b0.ex_in2, 32'd3);
      chk("nobyp_refresh_in1", b0.ex_in1, 32'd5);
      b1.ex_ready = 1'b1;
      issue(32'h001083B3);
      wb(1'b1, 5'd1, 32'd9);
      tick();
      chk_bundle("bypass", 32'd9, 32'd9, 3'b000, 1'b0, 5'd7);
      chk("nobyp_same_in1", b0.ex_in1, 32'd5);
      chk("nobyp_same_in2", b0.ex_in2, 32'd5);
      b1.instr_valid = 1'b0;
      wb(1'b1, 5'd0, 32'hDEADBEEF);
      tick();
      chk("idle_valid", {31'd0, b1.ex_valid}, 32'd0);
      wb(1'b0, 5'd0, 32'd0);
      issue(32'h00000433);
      tick();
      chk_bundle("x0", 32'd0, 32'd0, 3'b000, 1'b0, 5'd8);
      issue(32'h0000007F);
      tick();
      chk("ill_op_pulse", {31'd0, b1.illegal}, 32'd1);
      chk("ill_op_valid", {31'd0, b1.ex_valid}, 32'd0);
      b1.instr_valid = 1'b0;
      tick();
      chk("ill_op_end", {31'd0, b1.illegal}, 32'd0);
      issue(32'h40309493);
      tick();
      chk("ill_slli_pulse", {31'd0, b1.illegal}, 32'd1);
      chk("ill_slli_valid", {31'd0, b1.ex_valid}, 32'd0);
      b1.instr_valid = 1'b0;
      tick();
      chk("ill_slli_end", {31'd0, b1.illegal}, 32'd0);
      issue(32'h00100513);
      b1.ex_ready = 1'b1;
      #1 chk("s0_ready", {31'd0, b1.instr_ready}, 32'd1);
      tick();
      chk_bundle("s0", 32'd0, 32'd1, 3'b000, 1'b0, 5'd10);
      issue(32'h00200593);
      b1.ex_ready = 1'b0;
      #1 chk("s1_ready", {31'd0, b1.instr_ready}, 32'd0);
      tick();
      chk_bundle("s1_hold", 32'd0, 32'd1, 3'b000, 1'b0, 5'd10);
      b1.ex_ready = 1'b1;
      #1 chk("s2_ready", {31'd0, b1.instr_ready}, 32'd1);
      tick();
      chk_bundle("s2", 32'd0, 32'd2, 3'b000, 1'b0, 5'd11);
      issue(32'h00300613);
      #1 chk("s3_ready", {31'd0, b1.instr_ready}, 32'd1);
      tick();
      chk_bundle("s3", 32'd0, 32'd3, 3'b000, 1'b0, 5'd12);
      issue(32'h00400693);
      #1 chk("s4_ready", {31'd0, b1.instr_ready}, 32'd1);
      tick();
      chk_bundle("s4", 32'd0, 32'd4, 3'b000, 1'b0, 5'd13);
      b1.ex_ready = 1'b0;
      issue(32'h00100513);
      b1.flush = 1'b1;
      #1 chk("flush_ready", {31'd0, b1.instr_ready}, 32'd0);
      tick();
      chk("flush_valid", {31'd0, b1.ex_valid}, 32'd0);
      chk("flush_illegal", {31'd0, b1.illegal}, 32'd0);
      b1.flush = 1'b0;
      tick();
      chk_bundle("pre_rst", 32'd0, 32'd1, 3'b000, 1'b0, 5'd10);
      #2 rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      b1.instr_valid = 1'b0;
      b1.ex_ready = 1'b1;
      #1 rst_n = 1'b1;
      issue(32'h00208733);
      tick();
      chk_bundle("rf_cleared", 32'd0, 32'd0, 3'b000, 1'b0, 5'd14);
      b1.instr_valid = 1'b0;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode and operand-fetch stage that sits directly upstream of the integer ALU. It accepts one 32-bit RV32I OP or OP-IMM instruction per cycle and reads operands from an internal 32×32 register file with write-back bypass. It presents a registered `in1`/`in2`/`func3`/`opequal` bundle to the ALU under a valid/ready handshake. It also owns the architectural register file write port used by write-back.

## Interface
- `BYPASS_EN`, default 1: when 1, a same-cycle write-back is forwarded to operand reads and to held operands; when 0, the register-file read value is used.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `instr_valid` input 1: `instr` holds an instruction.
- `instr` input 32: instruction word.
- `instr_ready` output 1: stage accepts `instr` this cycle.
- `flush` input 1: discard the held bundle and any instruction offered this cycle.
- `wb_en` input 1: register write enable.
- `wb_rd` input 5: write-back destination register.
- `wb_data` input 32: write-back data.
- `ex_valid` output 1: bundle valid.
- `ex_ready` input 1: ALU consumes the bundle.
- `ex_in1` output 32: operand 1 (rs1 value).
- `ex_in2` output 32: operand 2 (rs2 value or immediate).
- `ex_func3` output 3: `instr[14:12]`.
- `ex_opequal` output 1: SUB/SRA qualifier.
- `ex_rd` output 5: destination register, carried to write-back.
- `illegal` output 1: one-cycle pulse for a rejected instruction.

## Operation
- Accept condition: `instr_valid && instr_ready`.
- `instr_ready = !flush && (!ex_valid || ex_ready)`. The output stage is a single entry with no skid buffer.
- Decode of OP, opcode `0110011`:
  - Legal when funct7 = `0000000`, or when funct7 = `0100000` with func3 ∈ {000, 101}.
  - `in2` = rs2 value.
  - `opequal = instr[30]`.
- Decode of OP-IMM, opcode `0010011`:
  - func3 = 001 is legal only with funct7 = `0000000`.
  - func3 = 101 is legal with funct7 = `0000000` or `0100000`.
  - All other func3 values are legal for any `imm`.
  - For func3 ∈ {001, 101}: `in2` = {27'b0, `instr[24:20]`}.
  - For all other func3: `in2` = `instr[31:20]` sign-extended to 32 bits.
  - `opequal = instr[30]` only when func3 = 101; otherwise 0. ADDI never subtracts.
- Illegal instruction (any other opcode, or an illegal funct7): the instruction is consumed, the bundle is not loaded, `ex_valid` is unaffected, and `illegal` = 1 on the next cycle.
- Register file:
  - x0 always reads 0.
  - A write with `wb_rd` = 0 is ignored.
  - All registers clear to 0 on reset.
- Read bypass (`BYPASS_EN` = 1): if `wb_en && wb_rd == rs && rs != 0`, the operand takes `wb_data` instead of the array value.
- Held-operand refresh: while `ex_valid && !ex_ready`, a write-back matching the held rs1 (or the held rs2, for OP only) updates `ex_in1`/`ex_in2` at the edge. Gated by `BYPASS_EN`. The stage stores rs1, rs2 and a uses-rs2 flag for this purpose.
- Flush:
  - At the next edge, `ex_valid` clears and `illegal` stays 0.
  - Register-file writes during flush still occur.
- Simultaneous accept and consume (`ex_valid && ex_ready && accept`): the new bundle replaces the old one without a bubble.

## Timing
- Latency: accept at edge N puts the bundle on `ex_*` with `ex_valid` = 1 after edge N. Throughput is 1 instruction per cycle when `ex_ready` = 1.
- Bundle stability: `ex_*` fields are stable while `ex_valid && !ex_ready`. The only exception is held-operand refresh.
- Write-back timing: the write occurs at the edge. A read in the same cycle sees the new value only via bypass.
- `illegal` is a registered, single-cycle pulse.
- Reset values: `ex_valid` = 0, `ex_in1`/`ex_in2` = 0, `ex_func3` = 0, `ex_opequal` = 0, `ex_rd` = 0, `illegal` = 0.
- `instr_ready` is combinational and equals 1 during reset release.
- Reset asserted mid-operation: state clears immediately and the held bundle is lost.

## Test plan
- Write x1 = 5 and x2 = 3, then issue `sub x3,x1,x2` (0x402081B3).
  - Required: one cycle later `ex_in1` = 5, `ex_in2` = 3, `ex_func3` = 000, `ex_opequal` = 1, `ex_rd` = 3.
- Issue `addi x4,x0,-1` (0xFFF00213), then `srai x5,x1,4` (0x4040D293).
  - Required for `addi`: `in1` = 0, `in2` = 0xFFFFFFFF, `opequal` = 0.
  - Required for `srai`: `in2` = 4, `opequal` = 1, `func3` = 101.
- Hold `ex_ready` = 0 with `add x6,x1,x2` held, then write-back x2 = 0x77.
  - Required: `ex_in2` becomes 0x77 and the other fields are unchanged. With `BYPASS_EN` = 0, `ex_in2` stays 3.
- In the same cycle, issue `add x7,x1,x1` with `wb_en=1, wb_rd=1, wb_data=9`.
  - Required: `ex_in1` = `ex_in2` = 9.
  - Also: a write to x0 followed by a read of x0 yields 0.
- Issue opcode 0x0000007F, then `slli` with funct7 = `0100000`.
  - Required: each produces one `illegal` pulse and `ex_valid` stays 0.
- Stream 4 back-to-back instructions with `ex_ready` toggling 1,0,1,1.
  - Required: no loss or duplication, and `instr_ready` is low exactly in the stalled cycle.
  - Then assert `flush` with a pending bundle: `ex_valid` = 0 next cycle.
  - Then pulse `rst_n` low mid-stream: all outputs return to 0 asynchronously.
